// File: rtl/regfile_param_bypass.sv
// Parametrised register file with an optional hard-wired zero entry, an optional write-to-read bypass,
// and a post-reset clear sequence that holds `ready` low until every storable entry is zero.
module regfile_param_bypass #(
    parameter int N        = 64,
    parameter int ADDR     = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    D,
    input  logic [ADDR-1:0] DA,
    input  logic            W,
    input  logic [ADDR-1:0] SA,
    input  logic [ADDR-1:0] SB,
    output logic [N-1:0]    A,
    output logic [N-1:0]    B,
    output logic            ready
);
    localparam int              DEPTH      = 2 ** ADDR;
    localparam bit              HAS_ZERO   = (ZERO_REG != 0);
    localparam bit              HAS_BYPASS = (BYPASS != 0);
    localparam int              LAST       = DEPTH - 1 - (HAS_ZERO ? 1 : 0);
    localparam logic [ADDR-1:0] LAST_IDX   = ADDR'(LAST);
    localparam logic [ADDR-1:0] TOP_IDX    = ADDR'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    logic [ADDR-1:0] cnt;
    // The zero register gets no storage; only entries 0..LAST exist.
    logic [N-1:0]    mem [0:LAST];

    logic da_is_zero;
    logic wr_run;

    assign da_is_zero = HAS_ZERO && (DA == TOP_IDX);
    assign wr_run     = (state == RUN) && W && !da_is_zero;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            if (cnt == LAST_IDX) begin
                state <= RUN;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + ADDR'(1);
            end
        end
    end

    // NOTE: storage has no reset branch; the clear sequence zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_run) begin
                mem[DA] <= D;
            end
        end
    end

    // NOTE: each read starts from a default and later assignments override it, so no latch is inferred.
    always_comb begin
        A = mem[SA];
        if (HAS_BYPASS && wr_run && (DA == SA)) A = D;
        if ((state == CLEAR) || (HAS_ZERO && (SA == TOP_IDX))) A = '0;
    end

    always_comb begin
        B = mem[SB];
        if (HAS_BYPASS && wr_run && (DA == SB)) B = D;
        if ((state == CLEAR) || (HAS_ZERO && (SB == TOP_IDX))) B = '0;
    end

endmodule

// File: tb/tb_regfile_param_bypass.sv
// Self-checking bench: default, no-bypass and small (16x8, no zero register) instances
// checked every cycle against a behavioural model, plus directed checks.
module tb_regfile_param_bypass;
    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] D;
    logic [4:0]  DA, SA, SB;
    logic        W;
    logic [63:0] A, B, nb_A, nb_B;
    logic        ready, nb_ready;

    logic [15:0] s_D, s_A, s_B;
    logic [2:0]  s_DA, s_SA, s_SB;
    logic        s_W, s_ready;

    int compared   = 0;
    int mismatched = 0;
    bit chk_on     = 1'b0;

    // Model: storage contents plus "edges of clear still to go" after each reset.
    logic [63:0] m_mem [32];
    bit          m_ready = 1'b0;
    int          m_left  = 0;
    logic [15:0] s_mem [8];
    bit          s_rdy_m = 1'b0;
    int          s_left  = 0;

    regfile_param_bypass dut (
        .clock(clock), .reset(reset), .D(D), .DA(DA), .W(W),
        .SA(SA), .SB(SB), .A(A), .B(B), .ready(ready)
    );

    regfile_param_bypass #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .D(D), .DA(DA), .W(W),
        .SA(SA), .SB(SB), .A(nb_A), .B(nb_B), .ready(nb_ready)
    );

    regfile_param_bypass #(.N(16), .ADDR(3), .ZERO_REG(0), .BYPASS(1)) dut_s (
        .clock(clock), .reset(reset), .D(s_D), .DA(s_DA), .W(s_W),
        .SA(s_SA), .SB(s_SB), .A(s_A), .B(s_B), .ready(s_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_big(input logic [4:0] sel, input bit byp);
        if (!m_ready || sel == 5'd31) return 64'h0;
        if (byp && W && DA == sel && DA != 5'd31) return D;
        return m_mem[sel];
    endfunction

    function automatic logic [15:0] ref_small(input logic [2:0] sel);
        if (!s_rdy_m) return 16'h0;
        if (s_W && s_DA == sel) return s_D;
        return s_mem[sel];
    endfunction

    // Check all outputs against the model, take one edge, advance the model.
    task automatic cycle();
        #1;
        if (chk_on) begin
            check("ready", 64'(ready), 64'(m_ready));
            check("nb_ready", 64'(nb_ready), 64'(m_ready));
            check("A", A, ref_big(SA, 1'b1));
            check("B", B, ref_big(SB, 1'b1));
            check("nb_A", nb_A, ref_big(SA, 1'b0));
            check("nb_B", nb_B, ref_big(SB, 1'b0));
            check("s_ready", 64'(s_ready), 64'(s_rdy_m));
            check("s_A", 64'(s_A), 64'(ref_small(s_SA)));
            check("s_B", 64'(s_B), 64'(ref_small(s_SB)));
        end
        @(posedge clock);
        if (reset) begin
            m_ready = 1'b0; m_left = 31;
            s_rdy_m = 1'b0; s_left = 8;
        end else begin
            if (!m_ready) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ready = 1'b1;
                        for (int i = 0; i < 31; i++) m_mem[i] = 64'h0;
                    end
                end
            end else if (W && DA != 5'd31) begin
                m_mem[DA] = D;
            end
            if (!s_rdy_m) begin
                if (s_left > 0) begin
                    s_left--;
                    if (s_left == 0) begin
                        s_rdy_m = 1'b1;
                        for (int i = 0; i < 8; i++) s_mem[i] = 16'h0;
                    end
                end
            end else if (s_W) begin
                s_mem[s_DA] = s_D;
            end
        end
        #1;
    endtask

    // Count edges after reset release until ready; bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(input string tag);
        int n   = 0;
        int s_n = -1;
        while (ready !== 1'b1 && n < 200) begin
            cycle();
            n++;
            if (s_n < 0 && s_ready === 1'b1) s_n = n;
        end
        check(tag, 64'(n), 64'd31);
        check({tag, "_small"}, 64'(s_n), 64'd8);
    endtask

    task automatic randomize_inputs();
        D  = {$urandom, $urandom};
        DA = 5'($urandom);
        W  = 1'($urandom);
        SA = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom);
        SB = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom);
        s_D  = 16'($urandom);
        s_DA = 3'($urandom);
        s_W  = 1'($urandom);
        s_SA = ($urandom_range(0, 3) == 0) ? s_DA : 3'($urandom);
        s_SB = 3'($urandom);
    endtask

    initial begin
        reset = 1'b1; W = 1'b0; D = '0; DA = '0; SA = '0; SB = '0;
        s_W = 1'b0; s_D = '0; s_DA = '0; s_SA = '0; s_SB = '0;

        // Reset clear: two reset edges, then count edges to ready with write attempts ignored.
        cycle();
        chk_on = 1'b1;
        cycle();
        reset = 1'b0;
        W = 1'b1; DA = 5'd4; D = 64'hBAD0_BAD0_BAD0_BAD0;
        s_W = 1'b1; s_DA = 3'd2; s_D = 16'hBAD0;
        wait_ready("ready_edges");
        W = 1'b0; s_W = 1'b0;
        for (int i = 0; i < 32; i++) begin
            SA = 5'(i); SB = 5'(31 - i);
            #1 check("cleared_A", A, 64'h0);
            cycle();
        end

        // Write/readback through both ports; zero register ignores writes.
        W = 1'b1;
        for (int i = 0; i < 31; i++) begin
            DA = 5'(i); D = 64'hDEADBEEF_00000000 + 64'(i);
            SA = 5'($urandom); SB = 5'($urandom);
            cycle();
        end
        DA = 5'd31; D = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        W = 1'b0;
        for (int i = 0; i < 31; i++) begin
            SA = 5'(i); SB = 5'(30 - i);
            #1;
            check("wr_A", A, 64'hDEADBEEF_00000000 + 64'(i));
            check("wr_B", B, 64'hDEADBEEF_00000000 + 64'(30 - i));
            cycle();
        end
        SA = 5'd31; SB = 5'd31;
        #1 check("zero_reg_A", A, 64'h0);
        cycle();

        // Bypass vs no-bypass in the write cycle, then both after the edge.
        W = 1'b1; DA = 5'd5; D = 64'h1234;
        cycle();
        D = 64'hABCD; SA = 5'd5; SB = 5'd5;
        #1;
        check("byp_A", A, 64'hABCD);
        check("byp_B", B, 64'hABCD);
        check("nobyp_A", nb_A, 64'h1234);
        check("nobyp_B", nb_B, 64'h1234);
        cycle();
        W = 1'b0;
        #1;
        check("nobyp_after_A", nb_A, 64'hABCD);
        check("nobyp_after_B", nb_B, 64'hABCD);
        cycle();

        // Reset from RUN: data hidden during clear and gone afterwards.
        W = 1'b1; DA = 5'd7; D = 64'h55; SA = 5'd7;
        cycle();
        W = 1'b0;
        #1 check("e7_written", A, 64'h55);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1 check("e7_in_clear", A, 64'h0);
        wait_ready("ready_from_run");
        #1 check("e7_cleared", A, 64'h0);
        cycle();

        // Reset mid-clear at cnt=10; writes to entry 3 during clear are dropped.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (10) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        W = 1'b1; DA = 5'd3; D = 64'h3333; SA = 5'd3;
        wait_ready("ready_mid_clear");
        W = 1'b0;
        #1 check("e3_after_clear", A, 64'h0);
        cycle();

        // Small instance: every entry writable, address 7 holds 16'hBEEF.
        s_W = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_DA = 3'(i); s_D = (i == 7) ? 16'hBEEF : 16'($urandom);
            cycle();
        end
        s_W = 1'b0; s_SA = 3'd7; s_SB = 3'd0;
        #1 check("small_e7", 64'(s_A), 64'hBEEF);
        cycle();

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (40) begin
            randomize_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
